// File: rtl/demux_stream.sv
// demux_stream: 1-to-N valid/ready stream demultiplexer with one register stage per lane.
// Each accepted beat is routed to lane `sel`. Lanes are independent: a stalled lane
// blocks only beats addressed to it.
// Optional feature: define DEMUX_STREAM_RR_EN to add rr_mode, which routes beats
// round-robin from an internal pointer instead of from sel.
module demux_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 1,
    localparam int unsigned N_OUT = 1 << SEL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
`ifdef DEMUX_STREAM_RR_EN
    input  logic                      rr_mode,
`endif
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic [N_OUT-1:0]          out_valid,
    input  logic [N_OUT-1:0]          out_ready,
    output logic                      busy,
    output logic [7:0]                beat_cnt
);

    logic [SEL_W-1:0]         dst_c;
    logic                     accept_c;
    logic [N_OUT-1:0]         load_c;
    logic [N_OUT-1:0]         valid_nxt;
    logic [N_OUT*DATA_W-1:0]  data_nxt;

`ifdef DEMUX_STREAM_RR_EN
    logic [SEL_W-1:0]         rr_ptr;
`endif

    // Destination select, acceptance and next lane contents; a load on a lane wins over its drain
    always_comb begin
        dst_c     = sel;
`ifdef DEMUX_STREAM_RR_EN
        if (rr_mode) begin
            dst_c = rr_ptr;
        end
`endif
        in_ready  = !rst && (!out_valid[dst_c] || out_ready[dst_c]);
        accept_c  = in_valid && in_ready;
        load_c    = '0;
        if (accept_c) begin
            load_c[dst_c] = 1'b1;
        end
        valid_nxt = (out_valid & ~out_ready) | load_c;
        data_nxt  = out_data;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (load_c[k]) begin
                data_nxt[k*DATA_W +: DATA_W] = in_data;
            end
        end
    end

    // Lane registers, busy flag and accepted-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            beat_cnt  <= 8'd0;
        end else begin
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            busy      <= |valid_nxt;
            if (accept_c) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef DEMUX_STREAM_RR_EN
    // Round-robin pointer: steps once per accepted beat while rr_mode is set
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (rr_mode && accept_c) begin
            rr_ptr <= rr_ptr + SEL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed vector table, corner sequences and randomized traffic
// checked against a lane-occupancy reference model for demux_stream (2 lanes, 8-bit data).
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        sel;
    logic        rr_mode;
    logic [15:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic        busy;
    logic [7:0]  beat_cnt;

    always #5 clk = ~clk;

    demux_stream #(.DATA_W(8), .SEL_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
`ifdef DEMUX_STREAM_RR_EN
        .rr_mode   (rr_mode),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which lanes hold an undelivered beat, last value per lane, beat count
    bit         occ  [2];
    logic [7:0] last [2];
    logic [7:0] cnt;
    int         ptr;
    logic       smp_ir;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        occ[0] = 0; occ[1] = 0;
        last[0] = 8'h00; last[1] = 8'h00;
        cnt = 8'd0;
        ptr = 0;
    endtask

    // One clock cycle: drive, check in_ready, clock, advance model, check registered outputs
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic s,
                         input logic [1:0] rdy, input logic rr);
        int  dst;
        bit  exp_ir;
        bit  acc;
        rst = r; in_valid = v; in_data = d; sel = s; out_ready = rdy; rr_mode = rr;
        #1;
        dst    = rr ? ptr : int'(s);
        exp_ir = !r && (!occ[dst] || rdy[dst]);
        smp_ir = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        acc = v && exp_ir;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++)
                if (occ[k] && rdy[k]) occ[k] = 0;
            if (acc) begin
                occ[dst]  = 1;
                last[dst] = d;
                cnt       = cnt + 8'd1;
                if (rr) ptr = (ptr + 1) % 2;
            end
        end
        chk("out_valid", 32'(out_valid), 32'({occ[1], occ[0]}));
        chk("out_data", 32'(out_data), 32'({last[1], last[0]}));
        chk("busy", 32'(busy), 32'(occ[0] || occ[1]));
        chk("beat_cnt", 32'(beat_cnt), 32'(cnt));
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       s;
        logic [1:0] rdy;
        logic       e_ir;
        logic [1:0] e_valid;
        logic [7:0] e_d0;
        logic [7:0] e_d1;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        model_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
        out_ready = 2'b00; rr_mode = 1'b0;

        // reset with a beat offered, basic routing, back-pressure isolation
        vecs[0] = '{1'b1, 1'b1, 8'h55, 1'b0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 2'b11, 1'b1, 2'b01, 8'hA5, 8'h00, 8'd1};
        vecs[3] = '{1'b0, 1'b1, 8'h3C, 1'b1, 2'b11, 1'b1, 2'b10, 8'hA5, 8'h3C, 8'd2};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b11, 1'b1, 2'b00, 8'hA5, 8'h3C, 8'd2};
        vecs[5] = '{1'b0, 1'b1, 8'h11, 1'b1, 2'b01, 1'b1, 2'b10, 8'hA5, 8'h11, 8'd3};
        vecs[6] = '{1'b0, 1'b1, 8'h22, 1'b1, 2'b01, 1'b0, 2'b10, 8'hA5, 8'h11, 8'd3};
        vecs[7] = '{1'b0, 1'b1, 8'h33, 1'b0, 2'b01, 1'b1, 2'b11, 8'h33, 8'h11, 8'd4};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 2'b10, 8'h33, 8'h11, 8'd4};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b11, 1'b1, 2'b00, 8'h33, 8'h11, 8'd4};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].rdy, 1'b0);
            chk($sformatf("vec%0d_in_ready", i), 32'(smp_ir), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_lane0", i), 32'(out_data[7:0]), 32'(vecs[i].e_d0));
            chk($sformatf("vec%0d_lane1", i), 32'(out_data[15:8]), 32'(vecs[i].e_d1));
            chk($sformatf("vec%0d_beat_cnt", i), 32'(beat_cnt), 32'(vecs[i].e_cnt));
        end

        // Full throughput on lane0 with an always-ready consumer
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0, 2'b11, 1'b0);
            chk("thru_in_ready", 32'(smp_ir), 32'd1);
            chk("thru_lane0", 32'({out_valid[0], out_data[7:0]}), 32'({1'b1, 8'(i)}));
        end
        chk("thru_beat_cnt", 32'(beat_cnt), 32'd10);

        // Counter wrap after 256 beats, then reset while lane0 holds a beat
        for (int i = 10; i < 256; i++)
            cycle(1'b0, 1'b1, 8'(i), 1'b0, 2'b11, 1'b0);
        chk("wrap_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("wrap_lane0_valid", 32'(out_valid[0]), 32'd1);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0, 2'b00, 1'b0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);

`ifdef DEMUX_STREAM_RR_EN
        // Round-robin ignores sel, then sel routing resumes
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b1, 2'b11, 1'b1);
            chk("rr_lane", 32'(out_valid), ((i % 2) == 1) ? 32'b01 : 32'b10);
            chk("rr_data", ((i % 2) == 1) ? 32'(out_data[7:0]) : 32'(out_data[15:8]), 32'(i));
        end
        cycle(1'b0, 1'b1, 8'h05, 1'b1, 2'b11, 1'b0);
        chk("rr_off_lane", 32'(out_valid), 32'b10);
        chk("rr_off_data", 32'(out_data[15:8]), 32'h05);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic rr;
`ifdef DEMUX_STREAM_RR_EN
            rr = 1'($urandom_range(0, 1));
`else
            rr = 1'b0;
`endif
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom), 2'($urandom), rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
